// File: rtl/yarp_pkg.sv
// Shared types for the YARP writeback stage: result-source select, load size,
// and the writeback FSM states.
package yarp_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2,
      WB_IMM = 2'd3
   } wb_sel_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } mem_size_t;

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_RSP = 1'b1
   } wb_state_t;

endpackage

// File: rtl/yarp_load_align.sv
// Combinational load-data aligner: picks the byte/half/word out of the raw
// memory word and sign- or zero-extends it to XLEN.
module yarp_load_align
   import yarp_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [31:0]     word_i,
   input  logic [1:0]      size_i,
   input  logic [1:0]      lsb_i,
   input  logic            zero_extnd_i,
   output logic [XLEN-1:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word_i[{lsb_i, 3'b000} +: 8];
      half_sel = lsb_i[1] ? word_i[31:16] : word_i[15:0];
      data_o   = '0;
      // Size 3 is not a legal encoding and falls through to the word case.
      case (mem_size_t'(size_i))
         SZ_BYTE: begin
            data_o       = {XLEN{~zero_extnd_i & byte_sel[7]}};
            data_o[7:0]  = byte_sel;
         end
         SZ_HALF: begin
            data_o       = {XLEN{~zero_extnd_i & half_sel[15]}};
            data_o[15:0] = half_sel;
         end
         default: begin
            data_o       = {XLEN{~zero_extnd_i & word_i[31]}};
            data_o[31:0] = word_i;
         end
      endcase
   end

endmodule

// File: rtl/yarp_writeback.sv
// Writeback stage: selects the result source, waits for load responses with a
// bounded timeout, and drives the register-file write port.
module yarp_writeback
   import yarp_pkg::*;
#(
   parameter int XLEN        = XLEN_DEFAULT,
   parameter int RSP_TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            instr_valid_i,
   output logic            ready_o,
   input  logic [4:0]      rd_addr_i,
   input  logic [1:0]      wb_sel_i,
   input  logic [XLEN-1:0] alu_res_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] imm_i,
   input  logic [1:0]      mem_size_i,
   input  logic            mem_zero_extnd_i,
   input  logic [1:0]      mem_addr_lsb_i,
   input  logic            mem_rsp_valid_i,
   input  logic [XLEN-1:0] mem_rsp_data_i,
   output logic            rf_wr_en_o,
   output logic [4:0]      rf_rd_addr_o,
   output logic [XLEN-1:0] rf_wr_data_o,
   output logic            load_pend_o,
   output logic [4:0]      load_pend_rd_o,
   output logic            timeout_err_o
);

   localparam int CW = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;

   wb_state_t       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            wr_en_q, wr_en_d;
   logic [4:0]      wr_addr_q, wr_addr_d;
   logic [XLEN-1:0] wr_data_q, wr_data_d;
   logic            pend_q, pend_d;
   logic [4:0]      pend_rd_q, pend_rd_d;
   logic [1:0]      size_q, size_d;
   logic            zx_q, zx_d;
   logic [1:0]      lsb_q, lsb_d;
   logic            tmo_q, tmo_d;
   logic [XLEN-1:0] load_data;
   logic [XLEN-1:0] direct_res;
   logic            tmo_hit;

   yarp_load_align #(.XLEN(XLEN)) u_align (
      .word_i       (mem_rsp_data_i[31:0]),
      .size_i       (size_q),
      .lsb_i        (lsb_q),
      .zero_extnd_i (zx_q),
      .data_o       (load_data)
   );

   assign ready_o = (state_q == IDLE);

   always_comb begin
      case (wb_sel_t'(wb_sel_i))
         WB_PC4:  direct_res = pc_i + XLEN'(4);
         WB_IMM:  direct_res = imm_i;
         default: direct_res = alu_res_i;
      endcase
      tmo_hit = (RSP_TIMEOUT != 0) && (cnt_q == CW'(RSP_TIMEOUT - 1));
   end

   // Handshake: an instruction is taken when instr_valid_i && ready_o; a load
   // response is consumed only while WAIT_RSP, anything else is dropped.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      pend_d    = pend_q;
      pend_rd_d = pend_rd_q;
      size_d    = size_q;
      zx_d      = zx_q;
      lsb_d     = lsb_q;
      tmo_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (instr_valid_i) begin
               if (wb_sel_t'(wb_sel_i) == WB_MEM) begin
                  state_d   = WAIT_RSP;
                  cnt_d     = '0;
                  pend_d    = 1'b1;
                  pend_rd_d = rd_addr_i;
                  size_d    = mem_size_i;
                  zx_d      = mem_zero_extnd_i;
                  lsb_d     = mem_addr_lsb_i;
               end else if (rd_addr_i != 5'd0) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = rd_addr_i;
                  wr_data_d = direct_res;
               end
            end
         end
         WAIT_RSP: begin
            if (mem_rsp_valid_i) begin
               state_d = IDLE;
               pend_d  = 1'b0;
               if (pend_rd_q != 5'd0) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = pend_rd_q;
                  wr_data_d = load_data;
               end
            end else if (tmo_hit) begin
               state_d = IDLE;
               pend_d  = 1'b0;
               tmo_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         pend_q    <= 1'b0;
         pend_rd_q <= '0;
         size_q    <= '0;
         zx_q      <= 1'b0;
         lsb_q     <= '0;
         tmo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         pend_q    <= pend_d;
         pend_rd_q <= pend_rd_d;
         size_q    <= size_d;
         zx_q      <= zx_d;
         lsb_q     <= lsb_d;
         tmo_q     <= tmo_d;
      end
   end

   assign rf_wr_en_o     = wr_en_q;
   assign rf_rd_addr_o   = wr_addr_q;
   assign rf_wr_data_o   = wr_data_q;
   assign load_pend_o    = pend_q;
   assign load_pend_rd_o = pend_rd_q;
   assign timeout_err_o  = tmo_q;

endmodule

// File: tb/tb_yarp_writeback.sv
// Directed bench for yarp_writeback: vector tables for direct and load
// writebacks plus hand sequences for stray responses, timeout and reset.
module tb_yarp_writeback;

   logic        clk = 1'b0;
   logic        reset;
   logic        instr_valid_i;
   logic        ready_o;
   logic [4:0]  rd_addr_i;
   logic [1:0]  wb_sel_i;
   logic [31:0] alu_res_i, pc_i, imm_i;
   logic [1:0]  mem_size_i;
   logic        mem_zero_extnd_i;
   logic [1:0]  mem_addr_lsb_i;
   logic        mem_rsp_valid_i;
   logic [31:0] mem_rsp_data_i;
   logic        rf_wr_en_o;
   logic [4:0]  rf_rd_addr_o;
   logic [31:0] rf_wr_data_o;
   logic        load_pend_o;
   logic [4:0]  load_pend_rd_o;
   logic        timeout_err_o;

   int total = 0;
   int bad   = 0;
   logic [36:0] exp_q[$];

   always #5 clk = ~clk;

   yarp_writeback #(.XLEN(32), .RSP_TIMEOUT(4)) dut (
      .clk              (clk),
      .reset            (reset),
      .instr_valid_i    (instr_valid_i),
      .ready_o          (ready_o),
      .rd_addr_i        (rd_addr_i),
      .wb_sel_i         (wb_sel_i),
      .alu_res_i        (alu_res_i),
      .pc_i             (pc_i),
      .imm_i            (imm_i),
      .mem_size_i       (mem_size_i),
      .mem_zero_extnd_i (mem_zero_extnd_i),
      .mem_addr_lsb_i   (mem_addr_lsb_i),
      .mem_rsp_valid_i  (mem_rsp_valid_i),
      .mem_rsp_data_i   (mem_rsp_data_i),
      .rf_wr_en_o       (rf_wr_en_o),
      .rf_rd_addr_o     (rf_rd_addr_o),
      .rf_wr_data_o     (rf_wr_data_o),
      .load_pend_o      (load_pend_o),
      .load_pend_rd_o   (load_pend_rd_o),
      .timeout_err_o    (timeout_err_o)
   );

   typedef struct {
      logic [4:0]  rd;
      logic [1:0]  sel;
      logic [31:0] alu;
      logic [31:0] pc;
      logic [31:0] imm;
      logic        en;
      logic [31:0] exp;
   } wb_vec_t;

   typedef struct {
      logic [4:0]  rd;
      logic [1:0]  size;
      logic        zx;
      logic [1:0]  lsb;
      logic [31:0] word;
      int          delay;
      logic        en;
      logic [31:0] exp;
   } ld_vec_t;

   wb_vec_t wv[5];
   ld_vec_t lv[8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Scoreboard: every register-file write must match the next expected write.
   always @(negedge clk) begin
      if (!reset && rf_wr_en_o) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: got rd=%0d data=%h want no write at %0t",
                     rf_rd_addr_o, rf_wr_data_o, $time);
         end else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            if ({rf_rd_addr_o, rf_wr_data_o} !== e) begin
               bad++;
               $display("FAIL write_data: got rd=%0d data=%h want rd=%0d data=%h at %0t",
                        rf_rd_addr_o, rf_wr_data_o, e[36:32], e[31:0], $time);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      instr_valid_i    = 1'b0;
      rd_addr_i        = '0;
      wb_sel_i         = '0;
      alu_res_i        = '0;
      pc_i             = '0;
      imm_i            = '0;
      mem_size_i       = '0;
      mem_zero_extnd_i = 1'b0;
      mem_addr_lsb_i   = '0;
      mem_rsp_valid_i  = 1'b0;
      mem_rsp_data_i   = '0;
   endtask

   task automatic issue_load(input logic [4:0] rd, input logic [1:0] size,
                             input logic zx, input logic [1:0] lsb);
      instr_valid_i    = 1'b1;
      wb_sel_i         = 2'd1;
      rd_addr_i        = rd;
      mem_size_i       = size;
      mem_zero_extnd_i = zx;
      mem_addr_lsb_i   = lsb;
      @(negedge clk);
      instr_valid_i    = 1'b0;
   endtask

   logic [31:0] last_data;

   initial begin
      wv[0] = '{rd: 5'd5,  sel: 2'd0, alu: 32'h1234_5678, pc: 32'h0,         imm: 32'h0,         en: 1'b1, exp: 32'h1234_5678};
      wv[1] = '{rd: 5'd9,  sel: 2'd2, alu: 32'h0,         pc: 32'hFFFF_FFFC, imm: 32'h0,         en: 1'b1, exp: 32'h0000_0000};
      wv[2] = '{rd: 5'd31, sel: 2'd3, alu: 32'h1111_1111, pc: 32'h0,         imm: 32'hDEAD_B000, en: 1'b1, exp: 32'hDEAD_B000};
      wv[3] = '{rd: 5'd1,  sel: 2'd2, alu: 32'h0,         pc: 32'h0000_0100, imm: 32'h5,         en: 1'b1, exp: 32'h0000_0104};
      wv[4] = '{rd: 5'd0,  sel: 2'd0, alu: 32'hAAAA_AAAA, pc: 32'h0,         imm: 32'h0,         en: 1'b0, exp: 32'h0};

      lv[0] = '{rd: 5'd7,  size: 2'd0, zx: 1'b0, lsb: 2'd2, word: 32'h0080_0000, delay: 3, en: 1'b1, exp: 32'hFFFF_FF80};
      lv[1] = '{rd: 5'd8,  size: 2'd1, zx: 1'b1, lsb: 2'd3, word: 32'h8001_0000, delay: 0, en: 1'b1, exp: 32'h0000_8001};
      lv[2] = '{rd: 5'd10, size: 2'd2, zx: 1'b0, lsb: 2'd1, word: 32'h89AB_CDEF, delay: 1, en: 1'b1, exp: 32'h89AB_CDEF};
      lv[3] = '{rd: 5'd11, size: 2'd0, zx: 1'b1, lsb: 2'd1, word: 32'h0000_F500, delay: 2, en: 1'b1, exp: 32'h0000_00F5};
      lv[4] = '{rd: 5'd12, size: 2'd1, zx: 1'b0, lsb: 2'd0, word: 32'h1234_8765, delay: 0, en: 1'b1, exp: 32'hFFFF_8765};
      lv[5] = '{rd: 5'd13, size: 2'd3, zx: 1'b1, lsb: 2'd2, word: 32'hCAFE_BABE, delay: 1, en: 1'b1, exp: 32'hCAFE_BABE};
      lv[6] = '{rd: 5'd14, size: 2'd0, zx: 1'b0, lsb: 2'd3, word: 32'h7F00_0000, delay: 2, en: 1'b1, exp: 32'h0000_007F};
      lv[7] = '{rd: 5'd0,  size: 2'd0, zx: 1'b0, lsb: 2'd0, word: 32'h0000_00FF, delay: 1, en: 1'b0, exp: 32'h0};

      // Clock/reset
      idle_inputs();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_wr_en",   {31'b0, rf_wr_en_o},    32'd0);
      chk("rst_addr",    {27'b0, rf_rd_addr_o},  32'd0);
      chk("rst_data",    rf_wr_data_o,           32'd0);
      chk("rst_pend",    {31'b0, load_pend_o},   32'd0);
      chk("rst_pend_rd", {27'b0, load_pend_rd_o},32'd0);
      chk("rst_tmo",     {31'b0, timeout_err_o}, 32'd0);
      chk("rst_ready",   {31'b0, ready_o},       32'd1);
      last_data = 32'h0;

      // Direct-result writebacks
      for (int i = 0; i < 5; i++) begin
         instr_valid_i = 1'b1;
         rd_addr_i     = wv[i].rd;
         wb_sel_i      = wv[i].sel;
         alu_res_i     = wv[i].alu;
         pc_i          = wv[i].pc;
         imm_i         = wv[i].imm;
         if (wv[i].en) begin
            exp_q.push_back({wv[i].rd, wv[i].exp});
            last_data = wv[i].exp;
         end
         @(negedge clk);
         instr_valid_i = 1'b0;
         chk("alu_wr_en", {31'b0, rf_wr_en_o}, {31'b0, wv[i].en});
         chk("alu_ready", {31'b0, ready_o}, 32'd1);
         @(negedge clk);
         chk("alu_pulse", {31'b0, rf_wr_en_o}, 32'd0);
         chk("alu_hold",  rf_wr_data_o, last_data);
      end

      // Load writebacks
      for (int i = 0; i < 8; i++) begin
         if (lv[i].en) exp_q.push_back({lv[i].rd, lv[i].exp});
         issue_load(lv[i].rd, lv[i].size, lv[i].zx, lv[i].lsb);
         chk("ld_ready",   {31'b0, ready_o},       32'd0);
         chk("ld_pend",    {31'b0, load_pend_o},   32'd1);
         chk("ld_pend_rd", {27'b0, load_pend_rd_o},{27'b0, lv[i].rd});
         for (int d = 0; d < lv[i].delay; d++) @(negedge clk);
         mem_rsp_valid_i = 1'b1;
         mem_rsp_data_i  = lv[i].word;
         @(negedge clk);
         mem_rsp_valid_i = 1'b0;
         chk("ld_wr_en",  {31'b0, rf_wr_en_o},    {31'b0, lv[i].en});
         chk("ld_done_ready", {31'b0, ready_o},   32'd1);
         chk("ld_done_pend",  {31'b0, load_pend_o}, 32'd0);
         chk("ld_no_tmo", {31'b0, timeout_err_o}, 32'd0);
      end

      // Stray response while idle
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = 32'h1234_FFFF;
      @(negedge clk);
      mem_rsp_valid_i = 1'b0;
      chk("stray_wr_en", {31'b0, rf_wr_en_o},    32'd0);
      chk("stray_tmo",   {31'b0, timeout_err_o}, 32'd0);

      // Timeout: four waiting cycles, then a one-cycle error pulse
      issue_load(5'd20, 2'd2, 1'b0, 2'd0);
      for (int c = 0; c < 4; c++) begin
         chk("tmo_wait_ready", {31'b0, ready_o},       32'd0);
         chk("tmo_wait_err",   {31'b0, timeout_err_o}, 32'd0);
         @(negedge clk);
      end
      chk("tmo_err",    {31'b0, timeout_err_o}, 32'd1);
      chk("tmo_wr_en",  {31'b0, rf_wr_en_o},    32'd0);
      chk("tmo_ready",  {31'b0, ready_o},       32'd1);
      chk("tmo_pend",   {31'b0, load_pend_o},   32'd0);
      @(negedge clk);
      chk("tmo_pulse",  {31'b0, timeout_err_o}, 32'd0);

      // Reset while waiting, then a late response
      issue_load(5'd21, 2'd2, 1'b0, 2'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = 32'h0000_0055;
      @(negedge clk);
      mem_rsp_valid_i = 1'b0;
      chk("rw_wr_en",   {31'b0, rf_wr_en_o},     32'd0);
      chk("rw_tmo",     {31'b0, timeout_err_o},  32'd0);
      chk("rw_addr",    {27'b0, rf_rd_addr_o},   32'd0);
      chk("rw_data",    rf_wr_data_o,            32'd0);
      chk("rw_pend",    {31'b0, load_pend_o},    32'd0);
      chk("rw_pend_rd", {27'b0, load_pend_rd_o}, 32'd0);
      chk("rw_ready",   {31'b0, ready_o},        32'd1);
      repeat (5) begin
         @(negedge clk);
         chk("rw_late_tmo", {31'b0, timeout_err_o}, 32'd0);
      end

      // Reset wins over a simultaneous accept
      reset         = 1'b1;
      instr_valid_i = 1'b1;
      wb_sel_i      = 2'd0;
      rd_addr_i     = 5'd3;
      alu_res_i     = 32'h0000_0077;
      @(negedge clk);
      reset         = 1'b0;
      instr_valid_i = 1'b0;
      chk("rp_wr_en", {31'b0, rf_wr_en_o}, 32'd0);
      @(negedge clk);
      chk("rp_wr_en2", {31'b0, rf_wr_en_o}, 32'd0);
      chk("rp_addr",   {27'b0, rf_rd_addr_o}, 32'd0);

      repeat (2) @(negedge clk);
      chk("exp_q_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/yarp_writeback.md
Name: yarp_writeback

Overview:
- Writeback stage of the YARP core. It sits directly upstream of the register file and drives its rd_addr_i, wr_en_i and wr_data_i.
- Selects the result source for each retiring instruction and waits for load responses from data memory.
- Aligns and sign/zero-extends load data, times out lost responses, and exposes the pending load destination to the hazard logic.

Parameters:
- XLEN, 32, datapath width.
- RSP_TIMEOUT, 16, cycles to wait for a load response before abandoning it; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- instr_valid_i  in  1  instruction presented by the execute stage
- ready_o  out  1  stage can accept an instruction this cycle
- rd_addr_i  in  5  destination register
- wb_sel_i  in  2  result source: ALU=0, MEM=1, PC4=2, IMM=3
- alu_res_i  in  XLEN  ALU result
- pc_i  in  XLEN  instruction PC
- imm_i  in  XLEN  immediate
- mem_size_i  in  2  BYTE=0, HALF=1, WORD=2
- mem_zero_extnd_i  in  1  1 = zero-extend load data, 0 = sign-extend
- mem_addr_lsb_i  in  2  load address bits [1:0]
- mem_rsp_valid_i  in  1  load response valid
- mem_rsp_data_i  in  XLEN  raw 32-bit memory word
- rf_wr_en_o  out  1  regfile write enable
- rf_rd_addr_o  out  5  regfile write address
- rf_wr_data_o  out  XLEN  regfile write data
- load_pend_o  out  1  a load is outstanding
- load_pend_rd_o  out  5  destination of the outstanding load
- timeout_err_o  out  1  one-cycle pulse when a load is abandoned

Behaviour:
- Single clock. Reset is synchronous and active-high; all state updates on posedge clk.
- Reset values: state=IDLE, rf_wr_en_o=0, rf_rd_addr_o=0, rf_wr_data_o=0, load_pend_o=0, load_pend_rd_o=0, timeout_err_o=0, timeout counter=0.
- Accept condition: instr_valid_i && ready_o. ready_o=1 only in IDLE (combinational from state).
- FSM states: IDLE, WAIT_RSP.
- IDLE, accept with wb_sel != MEM:
  - Next cycle: rf_wr_en_o=1, rf_rd_addr_o=rd_addr_i, rf_wr_data_o = alu_res_i, pc_i+4 (mod 2^32) or imm_i. Fixed latency of 1 cycle.
  - Stay in IDLE.
- IDLE, accept with wb_sel == MEM:
  - Capture rd_addr_i, mem_size_i, mem_zero_extnd_i and mem_addr_lsb_i.
  - Go to WAIT_RSP. load_pend_o=1 and load_pend_rd_o=rd from the next cycle.
- WAIT_RSP, mem_rsp_valid_i=1:
  - Next cycle: rf_wr_en_o=1 with the aligned data.
  - Return to IDLE; load_pend_o=0; ready_o=1 in that same cycle.
- Load alignment:
  - BYTE: selects byte lsb[1:0].
  - HALF: selects halfword lsb[1]; lsb[0] is ignored.
  - WORD: ignores lsb.
  - Extension into bits above the selected field follows mem_zero_extnd_i. Size value 3 is treated as WORD.
- Timeout:
  - Counter clears on entry to WAIT_RSP and increments each WAIT_RSP cycle without a response.
  - When the count reaches RSP_TIMEOUT-1 with no response: next cycle timeout_err_o=1 for one cycle, no write, return to IDLE.
  - A response arriving in that final cycle wins; no error is raised.
- rd == 0: the instruction is processed normally but rf_wr_en_o stays 0. x0 is never written by this stage.
- rf_wr_en_o is a single-cycle pulse per instruction. rf_rd_addr_o and rf_wr_data_o hold their last values when it is low.
- mem_rsp_valid_i in IDLE (stray or late response): ignored, no write, no error.
- Reset in WAIT_RSP: abandon the load silently with no timeout_err_o. A response arriving after reset is ignored.
- Reset has priority over accept and response in the same cycle.
- Register file read-after-write bypass is not this block's concern.

Decomposition:
- yarp_pkg holds:
  - wb_sel_t enum (ALU, MEM, PC4, IMM).
  - mem_size_t enum (BYTE, HALF, WORD).
  - wb_state_t enum (IDLE, WAIT_RSP).
  - XLEN localparam default.
- Sub-module yarp_load_align: purely combinational. Inputs are the raw word, size, lsb and zero-extend flag; output is the extended XLEN result. Instantiated once on the response path.

Test Plan:
- ALU writeback: accept wb_sel=ALU, rd=5, alu_res=0x1234_5678 -> next cycle rf_wr_en_o=1, rf_rd_addr_o=5, rf_wr_data_o=0x1234_5678; following cycle rf_wr_en_o=0.
- PC4 and IMM: pc=0xFFFF_FFFC with PC4 -> wr_data=0x0000_0000. IMM with imm=0xDEAD_B000 -> wr_data=0xDEAD_B000.
- Sign-extended byte load: rd=7, BYTE, lsb=2, zero_extnd=0, response 3 cycles later with data=0x0080_0000 -> wr_data=0xFFFF_FF80. ready_o=0 and load_pend_rd_o=7 while waiting.
- Zero-extended half load: HALF, lsb=3, zero_extnd=1, data=0x8001_0000 -> wr_data=0x0000_8001.
- rd=0 and stray response: load to rd=0 returns data -> rf_wr_en_o stays 0. mem_rsp_valid_i pulsed in IDLE -> no write.
- Timeout and reset: RSP_TIMEOUT=4, no response -> timeout_err_o pulses once, no write, ready_o=1. Second load with reset asserted in WAIT_RSP, then a late response -> no write, no error, all outputs at reset values.
